ro_sweep_ctrl: RTL
==================

RO_SWEEP_CTRL -- requirements
Module: ro_sweep_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, edge-count width.
REQ-002 SHALL have parameter SETTLE_CYC, default 16, clocks between start_o rise and gate open.
REQ-003 SHALL have parameter GATE_CYC, default 1024, gate window length in clocks.
REQ-004 SHALL have port wb_clk_i  in  1  single clock.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port go_i  in  1  one-cycle measurement request.
REQ-007 SHALL have port abort_i  in  1  cancel the current measurement or sweep.
REQ-008 SHALL have port code_i  in  5  initial select code, bit0..bit4 -> s1..s5.
REQ-009 SHALL have port tap_i  in  3  oscillator output to count, 0..4 -> X1_Y1..X5_Y1.
REQ-010 SHALL have port ro_x_i  in  5  asynchronous oscillator outputs X1_Y1..X5_Y1.
REQ-011 SHALL have port s_o  out  5  select lines to the oscillator.
REQ-012 SHALL have port start_o  out  1  oscillator enable.
REQ-013 SHALL have port busy_o  out  1  high whenever state is not IDLE.
REQ-014 SHALL have ports res_valid_o out 1, res_ready_i in 1, res_code_o out 5, res_count_o out CNT_W, res_ovf_o out 1; these form the result handshake.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, GATE, REPORT.
REQ-016 In IDLE, go_i=1 with abort_i=0 SHALL latch code_i and tap_i, drive s_o=code, and enter SETTLE on the next cycle.
REQ-017 start_o SHALL be 1 in SETTLE and GATE only; s_o SHALL hold the latched code outside IDLE and 0 in IDLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter GATE with the count cleared.
REQ-019 ro_x_i[tap] SHALL pass through a 2-flop synchronizer plus an edge-detect flop; each detected rising edge landing in a GATE cycle SHALL increment the count.
REQ-020 tap values 5..7 SHALL select no input, giving count 0.
REQ-021 The count SHALL saturate at 2^CNT_W-1 and set an overflow flag; it SHALL never wrap.
REQ-022 GATE SHALL last exactly GATE_CYC cycles, then enter REPORT with res_code_o, res_count_o and res_ovf_o registered and res_valid_o=1.
REQ-023 res_valid_o and all res_* outputs SHALL hold stable until the cycle with res_ready_i=1, which completes the transfer.
REQ-024 res_valid_o SHALL first assert SETTLE_CYC+GATE_CYC+1 cycles after the go_i cycle.
REQ-025 go_i SHALL be ignored while busy_o=1.
REQ-026 abort_i=1 in any state SHALL force IDLE on the next cycle, drop start_o and res_valid_o, and discard any pending result; abort_i SHALL win over a simultaneous go_i or res_ready_i.

Reset
REQ-027 wb_rst_i=1 SHALL asynchronously force IDLE, clear all counters and synchronizer flops, and set s_o=0, start_o=0, busy_o=0, res_valid_o=0, res_code_o=0, res_count_o=0, res_ovf_o=0.
REQ-028 Reset mid-measurement SHALL lose the measurement; no result SHALL be emitted.

Configuration
REQ-029 With macro RO_SWEEP_AUTO_EN defined, a completed transfer SHALL, when code<31, increment the code and re-enter SETTLE; after code 31 it SHALL return to IDLE. start_o SHALL be low for at least one cycle between points.
REQ-030 Without RO_SWEEP_AUTO_EN, a completed transfer SHALL always return to IDLE, giving one measurement per go_i.

Structure
REQ-031 The state enum, CODE_W=5 and TAP_W=3 SHALL live in shared package ro_ctrl_pkg.
REQ-032 The synchronizer with edge detect SHALL be sub-module ro_edge_sync, instantiated once on the muxed tap.

Verification
REQ-033 SETTLE_CYC=4, GATE_CYC=100, tap 0 toggling every 10 clocks, go_i with code 5'h0A -> s_o=0x0A, res_count_o in 4..5, res_valid_o exactly 105 cycles after go_i.
REQ-034 CNT_W=4, input toggling every 2 clocks for GATE_CYC=100 -> res_count_o=15, res_ovf_o=1.
REQ-035 res_ready_i held low for 20 cycles in REPORT -> res_* outputs stable for all 20 cycles, busy_o=1, a go_i pulse is ignored.
REQ-036 abort_i asserted in cycle 50 of GATE -> IDLE and start_o=0 on the next cycle, no res_valid_o.
REQ-037 wb_rst_i pulsed asynchronously mid-SETTLE -> all outputs 0 immediately, no result afterward.
REQ-038 With RO_SWEEP_AUTO_EN, code_i=30 and res_ready_i tied high -> two results with codes 30 and 31, start_o low between them, then IDLE.

Source files
------------

// File: rtl/ro_ctrl_pkg.sv
// Shared types and widths for the ring-oscillator sweep controller.
// Holds the FSM state encoding and the select/tap helpers.
package ro_ctrl_pkg;

   localparam int CODE_W   = 5;
   localparam int TAP_W    = 3;
   localparam int NUM_TAPS = 5;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      GATE,
      REPORT
   } state_t;

   // Taps 5..7 are unused and read as a constant low, so they never count.
   function automatic logic tap_mux(input logic [NUM_TAPS-1:0] x,
                                    input logic [TAP_W-1:0]    tap);
      case (tap)
         3'd0:    tap_mux = x[0];
         3'd1:    tap_mux = x[1];
         3'd2:    tap_mux = x[2];
         3'd3:    tap_mux = x[3];
         3'd4:    tap_mux = x[4];
         default: tap_mux = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// rise is a one-clock pulse, two clocks after din goes high.
module ro_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [1:0] sync_q;
   logic       last_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], din};
         last_q <= sync_q[1];
      end
   end

   assign rise = sync_q[1] & ~last_q;

endmodule

// File: rtl/ro_sweep_ctrl.sv
// Ring-oscillator measurement controller: select, settle, gate-count, report.
// Define RO_SWEEP_AUTO_EN to sweep the select code up to 31 after each accepted result.
module ro_sweep_ctrl
   import ro_ctrl_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int SETTLE_CYC = 16,
   parameter int GATE_CYC   = 1024
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                go_i,
   input  logic                abort_i,
   input  logic [CODE_W-1:0]   code_i,
   input  logic [TAP_W-1:0]    tap_i,
   input  logic [NUM_TAPS-1:0] ro_x_i,
   output logic [CODE_W-1:0]   s_o,
   output logic                start_o,
   output logic                busy_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [CODE_W-1:0]   res_code_o,
   output logic [CNT_W-1:0]    res_count_o,
   output logic                res_ovf_o
);

   localparam int TMR_MAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   logic [TMR_W-1:0]    tmr;
   logic [CODE_W-1:0]   code_q;
   logic [TAP_W-1:0]    tap_q;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic                ovf, ovf_nx;
   logic                tap_bit;
   logic                rise;

   assign tap_bit = tap_mux(ro_x_i, tap_q);

   ro_edge_sync u_edge_sync (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .din  (tap_bit),
      .rise (rise)
   );

   // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
   always_comb begin
      cnt_nx = cnt;
      ovf_nx = ovf;
      if (rise) begin
         if (cnt == CNT_MAX) ovf_nx = 1'b1;
         else                cnt_nx = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         tmr         <= '0;
         code_q      <= '0;
         tap_q       <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         s_o         <= '0;
         start_o     <= 1'b0;
         busy_o      <= 1'b0;
         res_valid_o <= 1'b0;
         res_code_o  <= '0;
         res_count_o <= '0;
         res_ovf_o   <= 1'b0;
      end else if (abort_i) begin
         state       <= IDLE;
         s_o         <= '0;
         start_o     <= 1'b0;
         busy_o      <= 1'b0;
         res_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go_i) begin
                  code_q  <= code_i;
                  tap_q   <= tap_i;
                  s_o     <= code_i;
                  start_o <= 1'b1;
                  busy_o  <= 1'b1;
                  tmr     <= TMR_W'(SETTLE_CYC - 1);
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (tmr == '0) begin
                  tmr   <= TMR_W'(GATE_CYC - 1);
                  cnt   <= '0;
                  ovf   <= 1'b0;
                  state <= GATE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            GATE: begin
               cnt <= cnt_nx;
               ovf <= ovf_nx;
               if (tmr == '0) begin
                  // An edge landing in the final gate clock still counts.
                  start_o     <= 1'b0;
                  res_valid_o <= 1'b1;
                  res_code_o  <= code_q;
                  res_count_o <= cnt_nx;
                  res_ovf_o   <= ovf_nx;
                  state       <= REPORT;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            REPORT: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
`ifdef RO_SWEEP_AUTO_EN
                  if (code_q != '1) begin
                     // REPORT already held start_o low for a clock between points.
                     code_q  <= code_q + CODE_W'(1);
                     s_o     <= code_q + CODE_W'(1);
                     start_o <= 1'b1;
                     tmr     <= TMR_W'(SETTLE_CYC - 1);
                     state   <= SETTLE;
                  end else begin
                     s_o    <= '0;
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end
`else
                  s_o    <= '0;
                  busy_o <= 1'b0;
                  state  <= IDLE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
